// File: rtl/game_pkg.sv
// Shared definitions for the board-game control blocks: FSM state encoding,
// board size and the player-count decode used by the scheduler and the counters.
package game_pkg;

    localparam int TILES = 24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FLIP = 3'd1,
        S_MOVE = 3'd2,
        S_NEXT = 3'd3,
        S_WIN  = 3'd4
    } state_t;

    // n_sel 3 is reserved and falls back to a two-player game
    function automatic logic [2:0] player_count(input logic [1:0] n_sel);
        logic [2:0] cnt;
        case (n_sel)
            2'd1:    cnt = 3'd3;
            2'd2:    cnt = 3'd4;
            default: cnt = 3'd2;
        endcase
        return cnt;
    endfunction

    function automatic logic [4:0] start_spacing(input logic [1:0] n_sel);
        logic [4:0] tiles;
        case (n_sel)
            2'd1:    tiles = 5'd8;
            2'd2:    tiles = 5'd6;
            default: tiles = 5'd12;
        endcase
        return tiles;
    endfunction

    function automatic logic [3:0] player_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Front-end / counter-bank signal bundle of the turn scheduler.
interface turn_scheduler_if;
    logic        start;
    logic [1:0]  n_sel;
    logic        match_valid;
    logic        match_ok;
    logic [3:0]  p_da;
    logic [1:0]  cur_player;
    logic [2:0]  state;
    logic [19:0] scores;
    logic        winner_valid;
    logic [1:0]  winner;

    modport master (
        output start, n_sel, match_valid, match_ok,
        input  p_da, cur_player, state, scores, winner_valid, winner
    );

    modport slave (
        input  start, n_sel, match_valid, match_ok,
        output p_da, cur_player, state, scores, winner_valid, winner
    );
endinterface

// File: rtl/score_bank.sv
// Four 5-bit successful-move counters that saturate at WIN_STEPS; one-hot
// increment, synchronous clear, asynchronous reset.
module score_bank #(
    parameter int WIN_STEPS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  inc,
    output logic [19:0] scores
);
    localparam logic [4:0] LIMIT = 5'(WIN_STEPS);

    logic [4:0] cnt_r [4];

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        // per-player saturating counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r[i] <= 5'd0;
            end else if (clr) begin
                cnt_r[i] <= 5'd0;
            end else if (inc[i] && (cnt_r[i] < LIMIT)) begin
                cnt_r[i] <= cnt_r[i] + 5'd1;
            end else begin
                cnt_r[i] <= cnt_r[i];
            end
        end
        assign scores[i*5 +: 5] = cnt_r[i];
    end
endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer for the 2-4 player board game: owns whose turn it is, issues
// the one-hot move enables and forfeits a turn when the flip times out.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int WIN_STEPS = 24,
    parameter int TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    turn_scheduler_if.slave  bus
);
    localparam int         CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [4:0] WIN_LIM = 5'(WIN_STEPS);

    state_t        state_r, next_s;
    logic [1:0]    cur_r, winner_r, nxt_player_s;
    logic [2:0]    pcnt_r;
    logic [CW-1:0] tmo_r;
    logic [3:0]    p_da_r, inc_s;
    logic          wv_r, start_s, hit_s;
    logic [4:0]    cur_score_s;
    logic [19:0]   scores_s;

    assign start_s = ((state_r == S_IDLE) || (state_r == S_WIN)) && bus.start;
    assign hit_s   = (state_r == S_FLIP) && bus.match_valid && bus.match_ok;
    assign inc_s   = hit_s ? player_onehot(cur_r) : 4'd0;
    assign nxt_player_s = (({1'b0, cur_r} + 3'd1) >= pcnt_r) ? 2'd0 : (cur_r + 2'd1);

    score_bank #(.WIN_STEPS(WIN_STEPS)) u_score_bank (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_s),
        .inc    (inc_s),
        .scores (scores_s)
    );

    // score of the player on turn, already updated when MOVE is reached
    always_comb begin
        case (cur_r)
            2'd0:    cur_score_s = scores_s[4:0];
            2'd1:    cur_score_s = scores_s[9:5];
            2'd2:    cur_score_s = scores_s[14:10];
            default: cur_score_s = scores_s[19:15];
        endcase
    end

    // next-state logic; a flip result in the timeout cycle takes priority
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE, S_WIN: begin
                if (bus.start) next_s = S_FLIP;
                else           next_s = state_r;
            end
            S_FLIP: begin
                if (bus.match_valid)      next_s = bus.match_ok ? S_MOVE : S_NEXT;
                else if (tmo_r == TO_LAST) next_s = S_NEXT;
                else                       next_s = S_FLIP;
            end
            S_MOVE: begin
                if (cur_score_s == WIN_LIM) next_s = S_WIN;
                else                        next_s = S_FLIP;
            end
            S_NEXT:  next_s = S_FLIP;
            default: next_s = S_IDLE;
        endcase
    end

    // state, timeout counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            tmo_r   <= '0;
            p_da_r  <= 4'd0;
            wv_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            tmo_r   <= ((state_r == S_FLIP) && (next_s == S_FLIP)) ? (tmo_r + CW'(1)) : '0;
            p_da_r  <= (next_s == S_MOVE) ? player_onehot(cur_r) : 4'd0;
            wv_r    <= (next_s == S_WIN);
        end
    end

    // game setup, turn rotation and winner capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_r    <= 2'd0;
            pcnt_r   <= 3'd2;
            winner_r <= 2'd0;
        end else begin
            if (start_s) begin
                cur_r  <= 2'd0;
                pcnt_r <= player_count(bus.n_sel);
            end else if (state_r == S_NEXT) begin
                cur_r  <= nxt_player_s;
                pcnt_r <= pcnt_r;
            end else begin
                cur_r  <= cur_r;
                pcnt_r <= pcnt_r;
            end
            if ((state_r == S_MOVE) && (next_s == S_WIN)) winner_r <= cur_r;
            else                                         winner_r <= winner_r;
        end
    end

    assign bus.p_da         = p_da_r;
    assign bus.cur_player   = cur_r;
    assign bus.state        = state_r;
    assign bus.scores       = scores_s;
    assign bus.winner_valid = wv_r;
    assign bus.winner       = winner_r;
endmodule

// File: tb/tb_turn_scheduler.sv
// Randomised bench for turn_scheduler with a behavioural game model and a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_turn_scheduler;
    localparam int WS = 24;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_scheduler_if tif ();
    turn_scheduler #(.WIN_STEPS(WS), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(tif));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int pda_pulses = 0;
    bit res_watch = 1'b0;
    bit res_bad = 1'b0;

    // behavioural game model; mode uses the display codes of the state output
    int m_mode, m_cur, m_players, m_age, m_pda, m_winner, m_wv;
    int m_score [4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_players = 2; m_age = 0;
        m_pda = 0; m_winner = 0; m_wv = 0;
        for (int i = 0; i < 4; i++) m_score[i] = 0;
    endtask

    task automatic model_step(input bit s, input int n, input bit mv, input bit mo);
        m_pda = 0;
        if (m_mode == 0 || m_mode == 4) begin
            if (s) begin
                m_players = (n == 1) ? 3 : (n == 2) ? 4 : 2;
                for (int i = 0; i < 4; i++) m_score[i] = 0;
                m_cur = 0; m_age = 0; m_mode = 1; m_wv = 0;
            end
        end else if (m_mode == 1) begin
            if (mv && mo) begin
                m_mode = 2;
                m_pda = 1 << m_cur;
                if (m_score[m_cur] < WS) m_score[m_cur]++;
            end else if (mv || m_age == TO - 1) begin
                m_mode = 3;
            end else begin
                m_age++;
            end
        end else if (m_mode == 2) begin
            if (m_score[m_cur] == WS) begin
                m_mode = 4; m_winner = m_cur; m_wv = 1;
            end else begin
                m_mode = 1; m_age = 0;
            end
        end else begin
            m_cur = (m_cur + 1) % m_players;
            m_age = 0; m_mode = 1;
        end
    endtask

    // one clock: present inputs, let the edge take them, then drop pulses
    task automatic cyc(input bit s, input int n, input bit mv, input bit mo);
        tif.start = s; tif.n_sel = 2'(n); tif.match_valid = mv; tif.match_ok = mo;
        @(posedge clk);
        model_step(s, n, mv, mo);
        #1;
        tif.start = 1'b0; tif.match_valid = 1'b0; tif.match_ok = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("state", int'(tif.state), m_mode);
                chk("cur_player", int'(tif.cur_player), m_cur);
                chk("p_da", int'(tif.p_da), m_pda);
                chk("scores", int'(tif.scores),
                    m_score[0] | (m_score[1] << 5) | (m_score[2] << 10) | (m_score[3] << 15));
                chk("winner_valid", int'(tif.winner_valid), m_wv);
                chk("winner", int'(tif.winner), m_winner);
                if (tif.p_da != 4'd0) pda_pulses++;
                if (res_watch && (tif.p_da[3:2] != 2'b00 || tif.cur_player > 2'd1)) res_bad = 1'b1;
            end
        end
    end

    initial begin
        int exp_cur [3];
        int r;
        exp_cur[0] = 1; exp_cur[1] = 0; exp_cur[2] = 1;
        tif.start = 1'b0; tif.n_sel = 2'd0; tif.match_valid = 1'b0; tif.match_ok = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // two players, three misses: 0 -> 1 -> 0 -> 1
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
            chk("rotate2_cur", int'(tif.cur_player), exp_cur[k]);
        end
        chk("rotate2_no_pda", pda_pulses, 0);

        // start mid-game is ignored: still two players
        cyc(1, 2, 0, 0);
        chk("midstart_state", int'(tif.state), 1);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
        chk("midstart_cur", int'(tif.cur_player), 0);

        // reset while in MOVE
        cyc(0, 0, 1, 1);
        chk("move_pda", int'(tif.p_da), 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pda", int'(tif.p_da), 0);
        chk("rst_state", int'(tif.state), 0);
        chk("rst_scores", int'(tif.scores), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // match in IDLE does nothing
        cyc(0, 0, 1, 1);
        chk("idle_match_state", int'(tif.state), 0);
        chk("idle_match_scores", int'(tif.scores), 0);

        // four players, player 0 wins with 24 straight matches
        cyc(1, 2, 0, 0);
        pda_pulses = 0;
        for (int k = 0; k < WS; k++) begin
            cyc(0, 0, 1, 1);
            cyc(0, 0, 0, 0);
        end
        chk("win_valid", int'(tif.winner_valid), 1);
        chk("win_winner", int'(tif.winner), 0);
        chk("win_score0", int'(tif.scores[4:0]), 24);
        chk("win_pulses", pda_pulses, 24);
        cyc(0, 0, 1, 1);
        chk("win_hold", int'(tif.state), 4);

        // restart from WIN with reserved n_sel: two-player rotation, fresh scores
        res_watch = 1'b1;
        cyc(1, 3, 0, 0);
        chk("restart_scores", int'(tif.scores), 0);
        chk("restart_cur", int'(tif.cur_player), 0);
        for (int k = 0; k < TO - 1; k++) cyc(0, 0, 0, 0);
        chk("tmo_still_flip", int'(tif.state), 1);
        cyc(0, 0, 0, 0);
        chk("tmo_next", int'(tif.state), 3);
        cyc(0, 0, 0, 0);
        chk("tmo_cur", int'(tif.cur_player), 1);
        for (int k = 0; k < TO - 1; k++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("tmo_edge_move", int'(tif.state), 2);
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, (k % 2) == 0, 1'b0);
        chk("reserved_only_01", int'(res_bad), 0);
        res_watch = 1'b0;

        // randomised play
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
            end else begin
                cyc(r < 30, $urandom_range(0, 3), $urandom_range(0, 99) < 45,
                    $urandom_range(0, 99) < 80);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
